board_render: RTL

Parametrised VGA renderer for an N-column by M-row drop-piece game board: grid, two-player pieces, a column-cursor marker and blinking winning pieces.
- Generates its own 640x480@60 timing from a single pixel clock.
- Snapshots the board state once per frame so game-logic updates cannot tear the image.
- Drives the board monitor directly and replaces the fixed 7x6 renderer at the display end of the game datapath.

---
 rtl/board_render.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/board_render.sv
// board_render: VGA renderer for a COLS x ROWS drop-piece board (grid, pieces, cursor marker, blinking winners).
// Latency: RGB and syncs are 2 cycles after the pixel counters; frame_start is decoded directly from the counters.
// Backpressure: none, the raster is free-running; board inputs are sampled once per frame at frame_start.
// Ports: clk (pixel clock), reset (async active-low), occupied/owner/win_mask (index row*COLS+col, row 0 = bottom),
//        cursor_col/cursor_en/turn (drop cursor marker), vga_h_sync/vga_v_sync (active-low), vga_r/g/b, frame_start.
// Option: define BOARD_RENDER_BLINK_EN to make winning pieces blink; otherwise they are steady white.
// H_*/V_* parameters default to standard 640x480@60 timing.
module board_render #(
  parameter int COLS         = 7,
  parameter int ROWS         = 6,
  parameter int CELL         = 64,
  parameter int LINE_W       = 4,
  parameter int MARGIN       = 8,
  parameter int X0           = 96,
  parameter int Y0           = 80,
  parameter int BLINK_FRAMES = 30,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [ROWS*COLS-1:0]                   occupied,
  input  logic [ROWS*COLS-1:0]                   owner,
  input  logic [ROWS*COLS-1:0]                   win_mask,
  input  logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] cursor_col,
  input  logic                                   cursor_en,
  input  logic                                   turn,
  output logic                                   vga_h_sync,
  output logic                                   vga_v_sync,
  output logic                                   vga_r,
  output logic                                   vga_g,
  output logic                                   vga_b,
  output logic                                   frame_start
);

  localparam int N       = ROWS * COLS;
  localparam int CCW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int OW      = $clog2(CELL);
  localparam int CW      = $clog2(COLS + 2);
  localparam int RW      = $clog2(ROWS + 2);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_X0   = HW'(X0);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_Y0   = VW'(Y0);
  localparam logic [VW-1:0] V_BAND = VW'(Y0 - CELL);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] B_PLO  = VW'(LINE_W + MARGIN);
  localparam logic [VW-1:0] B_PHI  = VW'(CELL - MARGIN - 1);
  localparam logic [OW-1:0] O_LAST = OW'(CELL - 1);
  localparam logic [OW-1:0] O_LW   = OW'(LINE_W);
  localparam logic [OW-1:0] O_PLO  = OW'(LINE_W + MARGIN);
  localparam logic [OW-1:0] O_PHI  = OW'(CELL - MARGIN - 1);
  localparam logic [CW-1:0] COLS_C = CW'(COLS);
  localparam logic [CW-1:0] COL_SAT = CW'(COLS + 1);
  localparam logic [RW-1:0] ROWS_C = RW'(ROWS);
  localparam logic [RW-1:0] ROW_SAT = RW'(ROWS + 1);

  // ---------------- stage 0: raster counters and incremental cell tracking
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic          h_wrap;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + HW'(1);
    v_nxt  = v_cnt;
    if (h_wrap) v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // col_idx/x_off describe the current h_cnt; they are reloaded each line as the
  // counter enters X0, and col_idx saturates past the closing line so it never wraps back into the board.
  logic [OW-1:0] x_off, y_off;
  logic [CW-1:0] col_idx;
  logic [RW-1:0] row_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_off   <= '0;
      col_idx <= '0;
    end else if (h_nxt == H_X0) begin
      x_off   <= '0;
      col_idx <= '0;
    end else if (x_off == O_LAST) begin
      x_off <= '0;
      if (col_idx != COL_SAT) col_idx <= col_idx + CW'(1);
    end else begin
      x_off <= x_off + OW'(1);
    end
  end

  // Row tracking steps once per line; row_idx counts displayed rows top-down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_off   <= '0;
      row_idx <= '0;
    end else if (h_wrap) begin
      if (v_nxt == V_Y0) begin
        y_off   <= '0;
        row_idx <= '0;
      end else if (y_off == O_LAST) begin
        y_off <= '0;
        if (row_idx != ROW_SAT) row_idx <= row_idx + RW'(1);
      end else begin
        y_off <= y_off + OW'(1);
      end
    end
  end

  // ---------------- per-frame snapshot of the board inputs
  logic [N-1:0]   occ_s, own_s, win_s;
  logic [CCW-1:0] cur_s;
  logic           cen_s, turn_s;

  assign frame_start = (h_cnt == '0) && (v_cnt == V_ACT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_s  <= '0;
      own_s  <= '0;
      win_s  <= '0;
      cur_s  <= '0;
      cen_s  <= 1'b0;
      turn_s <= 1'b0;
    end else if (frame_start) begin
      occ_s  <= occupied;
      own_s  <= owner;
      win_s  <= win_mask;
      cur_s  <= cursor_col;
      cen_s  <= cursor_en;
      turn_s <= turn;
    end
  end

  logic blink_on;
`ifdef BOARD_RENDER_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`else
  assign blink_on = 1'b1;
`endif

  // ---------------- stage 1: pixel classification
  logic          x_in, y_in, x_sq, y_sq, in_cell, in_band;
  logic [VW-1:0] band_off;
  logic          grid_c, piece_c, marker_c, act_c, hs_c, vs_c;

  always_comb begin
    x_in     = (h_cnt >= H_X0) && ((col_idx < COLS_C) || ((col_idx == COLS_C) && (x_off < O_LW)));
    y_in     = (v_cnt >= V_Y0) && ((row_idx < ROWS_C) || ((row_idx == ROWS_C) && (y_off < O_LW)));
    x_sq     = (x_off >= O_PLO) && (x_off <= O_PHI);
    y_sq     = (y_off >= O_PLO) && (y_off <= O_PHI);
    in_cell  = (h_cnt >= H_X0) && (col_idx < COLS_C) && (v_cnt >= V_Y0) && (row_idx < ROWS_C);
    in_band  = (v_cnt >= V_BAND) && (v_cnt < V_Y0);
    band_off = v_cnt - V_BAND;
    grid_c   = x_in && y_in && ((x_off < O_LW) || (y_off < O_LW));
    piece_c  = in_cell && x_sq && y_sq;
    // col_idx < COLS together with the equality means a cursor_col >= COLS never matches.
    marker_c = in_band && (band_off >= B_PLO) && (band_off <= B_PHI) && (h_cnt >= H_X0) &&
               (col_idx < COLS_C) && (col_idx == CW'(cur_s)) && x_sq;
    act_c    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_c     = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_c     = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  end

  logic          act_q, grid_q, piece_q, marker_q, hs_q, vs_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] srow_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q    <= 1'b0;
      grid_q   <= 1'b0;
      piece_q  <= 1'b0;
      marker_q <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      col_q    <= '0;
      srow_q   <= '0;
    end else begin
      act_q    <= act_c;
      grid_q   <= grid_c;
      piece_q  <= piece_c;
      marker_q <= marker_c;
      hs_q     <= hs_c;
      vs_q     <= vs_c;
      col_q    <= col_idx;
      srow_q   <= RW'(ROWS - 1) - row_idx;  // stored rows count bottom-up
    end
  end

  // ---------------- stage 2: cell lookup by one-hot select, then colour priority
  logic [N-1:0] cell_hit;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign cell_hit[r*COLS + c] = (srow_q == RW'(r)) && (col_q == CW'(c));
    end
  end

  logic       cell_occ, cell_own, cell_win;
  logic [2:0] rgb_nxt;

  always_comb begin
    cell_occ = |(occ_s & cell_hit);
    cell_own = |(own_s & cell_hit);
    cell_win = |(win_s & cell_hit);
    rgb_nxt  = 3'b000;
    if (act_q) begin
      if (grid_q) begin
        rgb_nxt = 3'b001;
      end else if (piece_q && cell_occ) begin
        if (cell_win && blink_on) rgb_nxt = 3'b111;
        else                      rgb_nxt = cell_own ? 3'b110 : 3'b100;
      end else if (marker_q && cen_s) begin
        rgb_nxt = turn_s ? 3'b110 : 3'b100;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {vga_r, vga_g, vga_b} <= 3'b000;
      vga_h_sync            <= 1'b1;
      vga_v_sync            <= 1'b1;
    end else begin
      {vga_r, vga_g, vga_b} <= rgb_nxt;
      vga_h_sync            <= hs_q;
      vga_v_sync            <= vs_q;
    end
  end

endmodule
